// File: rtl/bip_debug_ctrl.sv
// Debug/run controller between a UART byte stream and the BIP core: program load,
// run-until-halt, single step, and a 6-byte PC/ACC/cycle-count status report.
`timescale 1ns/1ps
module bip_debug_ctrl #(
    parameter int NBITS_O   = 11,
    parameter int NBITS_D   = 16,
    parameter int NBITS_CYC = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [7:0]         i_rx_data,
    input  logic               i_rx_valid,
    output logic [7:0]         o_tx_data,
    output logic               o_tx_start,
    input  logic               i_tx_busy,
    output logic               o_bip_en,
    output logic               o_bip_reset,
    input  logic               i_bip_halt,
    input  logic [NBITS_O-1:0] i_bip_pc,
    input  logic [NBITS_D-1:0] i_bip_acc,
    output logic               o_prog_we,
    output logic [NBITS_O-1:0] o_prog_addr,
    output logic [NBITS_D-1:0] o_prog_data,
    output logic [3:0]         o_dbg_state
);

    // Handshakes: i_rx_valid is a one-cycle strobe with no backpressure (bytes arriving
    // outside IDLE/LD_CNT/LD_HI/LD_LO are dropped); o_tx_start is a one-cycle strobe
    // issued only when i_tx_busy was sampled 0, with o_tx_data held until the next start.
    typedef enum logic [3:0] {
        IDLE, LD_CNT, LD_HI, LD_LO, LD_WR, RUN, STEP, RPT_LATCH, RPT_SEND, RPT_WAIT
    } state_t;

    state_t               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [NBITS_O-1:0]   idx_q, idx_d;
    logic [7:0]           hi_q, hi_d;
    logic [47:0]          rpt_q, rpt_d;
    logic [2:0]           bidx_q, bidx_d;
    logic [NBITS_CYC-1:0] cyc_q, cyc_d;
    logic                 cyc_clr;
    logic                 en_d, bip_rst_d, we_d, start_d;
    logic [NBITS_O-1:0]   addr_d;
    logic [NBITS_D-1:0]   data_d;
    logic [7:0]           tx_d;

    assign o_dbg_state = state_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        hi_d    = hi_q;
        rpt_d   = rpt_q;
        bidx_d  = bidx_q;
        cyc_d   = cyc_q;
        cyc_clr = 1'b0;
        en_d    = 1'b0;
        we_d    = 1'b0;
        start_d = 1'b0;
        addr_d  = o_prog_addr;
        data_d  = o_prog_data;
        tx_d    = o_tx_data;

        if (o_bip_en && (cyc_q != '1))
            cyc_d = cyc_q + NBITS_CYC'(1);

        unique case (state_q)
            IDLE: begin
                if (i_rx_valid) begin
                    case (i_rx_data)
                        8'h4C:   state_d = LD_CNT;
                        8'h52:   state_d = RUN;
                        8'h53:   state_d = STEP;
                        8'h50:   state_d = RPT_LATCH;
                        default: state_d = IDLE;
                    endcase
                end
            end
            LD_CNT: begin
                if (i_rx_valid) begin
                    if (i_rx_data == 8'd0) begin
                        state_d = IDLE;
                        cyc_clr = 1'b1;
                    end else begin
                        cnt_d   = i_rx_data;
                        idx_d   = '0;
                        state_d = LD_HI;
                    end
                end
            end
            LD_HI: begin
                if (i_rx_valid) begin
                    hi_d    = i_rx_data;
                    state_d = LD_LO;
                end
            end
            LD_LO: begin
                if (i_rx_valid) begin
                    data_d  = NBITS_D'({hi_q, i_rx_data});
                    addr_d  = idx_q;
                    we_d    = 1'b1;
                    state_d = LD_WR;
                end
            end
            LD_WR: begin
                idx_d = idx_q + NBITS_O'(1);
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    state_d = IDLE;
                    cyc_clr = 1'b1;
                end else begin
                    state_d = LD_HI;
                end
            end
            RUN: begin
                // Halt sampled during an enabled cycle ends the run on the following cycle.
                if (i_bip_halt) state_d = RPT_LATCH;
                else            en_d    = 1'b1;
            end
            STEP: begin
                if (o_bip_en || i_bip_halt) state_d = RPT_LATCH;
                else                        en_d    = 1'b1;
            end
            RPT_LATCH: begin
                rpt_d   = {16'(i_bip_pc), 16'(i_bip_acc), 16'(cyc_q)};
                bidx_d  = 3'd0;
                state_d = RPT_SEND;
            end
            RPT_SEND: begin
                if (!i_tx_busy) begin
                    start_d = 1'b1;
                    tx_d    = rpt_q[47:40];
                    state_d = RPT_WAIT;
                end
            end
            RPT_WAIT: begin
                // The start cycle itself is skipped: the transmitter raises busy only after it.
                if (!o_tx_start && !i_tx_busy) begin
                    if (bidx_q == 3'd5) begin
                        state_d = IDLE;
                    end else begin
                        bidx_d  = bidx_q + 3'd1;
                        rpt_d   = {rpt_q[39:0], 8'h00};
                        state_d = RPT_SEND;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (cyc_clr)
            cyc_d = '0;
        bip_rst_d = (state_d == LD_CNT) || (state_d == LD_HI) ||
                    (state_d == LD_LO)  || (state_d == LD_WR);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            hi_q        <= '0;
            rpt_q       <= '0;
            bidx_q      <= '0;
            cyc_q       <= '0;
            o_bip_en    <= 1'b0;
            o_bip_reset <= 1'b1;
            o_prog_we   <= 1'b0;
            o_prog_addr <= '0;
            o_prog_data <= '0;
            o_tx_start  <= 1'b0;
            o_tx_data   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            hi_q        <= hi_d;
            rpt_q       <= rpt_d;
            bidx_q      <= bidx_d;
            cyc_q       <= cyc_d;
            o_bip_en    <= en_d;
            o_bip_reset <= bip_rst_d;
            o_prog_we   <= we_d;
            o_prog_addr <= addr_d;
            o_prog_data <= data_d;
            o_tx_start  <= start_d;
            o_tx_data   <= tx_d;
        end
    end

endmodule

// File: tb/tb_bip_debug_ctrl.sv
// Bench for bip_debug_ctrl: a BIP core model with HLT at a fixed address, a busy-driven
// transmitter, and a command-level model that predicts writes, reports and enable counts.
`timescale 1ns/1ps
module tb_bip_debug_ctrl;
    localparam int NBITS_O   = 11;
    localparam int NBITS_D   = 16;
    localparam int NBITS_CYC = 16;
    localparam int HLT_ADDR  = 4;

    logic               clk = 1'b0;
    logic               i_reset;
    logic [7:0]         i_rx_data;
    logic               i_rx_valid;
    logic [7:0]         o_tx_data;
    logic               o_tx_start;
    logic               i_tx_busy = 1'b0;
    logic               o_bip_en;
    logic               o_bip_reset;
    logic               i_bip_halt;
    logic [NBITS_O-1:0] i_bip_pc;
    logic [NBITS_D-1:0] i_bip_acc;
    logic               o_prog_we;
    logic [NBITS_O-1:0] o_prog_addr;
    logic [NBITS_D-1:0] o_prog_data;
    logic [3:0]         o_dbg_state;

    // ---------------- clock / reset
    always #5 clk = ~clk;

    bip_debug_ctrl #(.NBITS_O(NBITS_O), .NBITS_D(NBITS_D), .NBITS_CYC(NBITS_CYC)) dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
        .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_busy(i_tx_busy),
        .o_bip_en(o_bip_en), .o_bip_reset(o_bip_reset), .i_bip_halt(i_bip_halt),
        .i_bip_pc(i_bip_pc), .i_bip_acc(i_bip_acc),
        .o_prog_we(o_prog_we), .o_prog_addr(o_prog_addr), .o_prog_data(o_prog_data),
        .o_dbg_state(o_dbg_state)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- BIP core model: PC advances per enable, HLT sits at HLT_ADDR
    logic [NBITS_O-1:0] bip_pc = '0;
    logic               halt_force = 1'b0;

    function automatic logic [15:0] acc_of(input int pc);
        return 16'(8 * pc + 2);
    endfunction

    always @(posedge clk) begin
        if (o_bip_reset)   bip_pc <= '0;
        else if (o_bip_en) bip_pc <= bip_pc + 1'b1;
    end
    assign i_bip_halt = halt_force || (int'(bip_pc) >= HLT_ADDR);
    assign i_bip_pc   = bip_pc;
    assign i_bip_acc  = acc_of(int'(bip_pc));

    // ---------------- transmitter model: busy for busy_len cycles after each start
    int busy_len = 2;
    always begin
        @(negedge clk);
        if (o_tx_start === 1'b1) begin
            @(posedge clk);
            #1 i_tx_busy = 1'b1;
            repeat (busy_len) @(posedge clk);
            #1 i_tx_busy = 1'b0;
        end
    end

    logic busy_at_edge = 1'b0;
    always @(posedge clk) busy_at_edge <= i_tx_busy;

    // ---------------- scoreboard
    logic [7:0]  exp_tx[$];
    logic [26:0] exp_prog[$];
    logic [7:0]  tx_log[$];
    logic [26:0] prog_log[$];
    int          en_seen = 0;

    always @(negedge clk) begin
        if (!i_reset) begin
            if (o_prog_we) begin
                prog_log.push_back({o_prog_addr, o_prog_data});
                check("prog_we_expected", 32'(exp_prog.size() != 0), 32'd1);
                if (exp_prog.size() != 0) begin
                    logic [26:0] e;
                    e = exp_prog.pop_front();
                    check("prog_addr", 32'(o_prog_addr), 32'(e[26:16]));
                    check("prog_data", 32'(o_prog_data), 32'(e[15:0]));
                end
                check("prog_we_under_reset", 32'(o_bip_reset), 32'd1);
            end
            if (o_tx_start) begin
                tx_log.push_back(o_tx_data);
                check("tx_start_expected", 32'(exp_tx.size() != 0), 32'd1);
                if (exp_tx.size() != 0) check("tx_byte", 32'(o_tx_data), 32'(exp_tx.pop_front()));
                check("tx_start_when_idle", 32'(busy_at_edge), 32'd0);
            end
            if (o_bip_en) begin
                en_seen++;
                check("en_not_in_reset", 32'(o_bip_reset), 32'd0);
            end
        end
    end

    // ---------------- command-level model
    int exp_pc  = 0;
    int exp_cyc = 0;

    function automatic bit model_halted();
        return halt_force || (exp_pc >= HLT_ADDR);
    endfunction

    task automatic push_report();
        logic [15:0] pc16, acc16, cyc16;
        pc16  = 16'(exp_pc);
        acc16 = acc_of(exp_pc);
        cyc16 = 16'(exp_cyc);
        exp_tx.push_back(pc16[15:8]);  exp_tx.push_back(pc16[7:0]);
        exp_tx.push_back(acc16[15:8]); exp_tx.push_back(acc16[7:0]);
        exp_tx.push_back(cyc16[15:8]); exp_tx.push_back(cyc16[7:0]);
    endtask

    // ---------------- driver tasks
    task automatic send_byte(input logic [7:0] b);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        @(posedge clk);
        #1 i_rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_report(input string name);
        int t = 0;
        while (exp_tx.size() != 0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        check({name, "_tx_timeout"}, 32'(exp_tx.size()), 32'd0);
        exp_tx.delete();
        repeat (busy_len + 6) @(posedge clk);
        #1;
    endtask

    logic [15:0] load_words[$];

    task automatic do_load(input string name);
        logic [7:0]  bytes[$];
        logic [15:0] w;
        exp_pc  = 0;
        exp_cyc = 0;
        bytes.push_back(8'h4C);
        bytes.push_back(8'(load_words.size()));
        foreach (load_words[i]) begin
            w = load_words[i];
            exp_prog.push_back({11'(i), w});
            bytes.push_back(w[15:8]);
            bytes.push_back(w[7:0]);
        end
        foreach (bytes[i]) begin
            send_byte(bytes[i]);
            if (i < bytes.size() - 1) check({name, "_bip_reset_held"}, 32'(o_bip_reset), 32'd1);
        end
        check({name, "_bip_reset_released"}, 32'(o_bip_reset), 32'd0);
        check({name, "_all_writes"}, 32'(exp_prog.size()), 32'd0);
    endtask

    // is_run=1: 'R', is_run=0: 'S'
    task automatic do_exec(input bit is_run, input string name);
        int n, en0;
        if (model_halted()) n = 0;
        else                n = is_run ? (HLT_ADDR - exp_pc + 1) : 1;
        exp_pc  += n;
        exp_cyc = (exp_cyc + n > 65535) ? 65535 : exp_cyc + n;
        push_report();
        en0 = en_seen;
        tx_log.delete();
        send_byte(is_run ? 8'h52 : 8'h53);
        wait_report(name);
        check({name, "_en_cycles"}, 32'(en_seen - en0), 32'(n));
        check({name, "_tx_count"}, 32'(tx_log.size()), 32'd6);
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_bip_reset"}, 32'(o_bip_reset), 32'd1);
        check({name, "_bip_en"},    32'(o_bip_en),    32'd0);
        check({name, "_tx_start"},  32'(o_tx_start),  32'd0);
        check({name, "_tx_data"},   32'(o_tx_data),   32'd0);
        check({name, "_prog_we"},   32'(o_prog_we),   32'd0);
        check({name, "_prog_addr"}, 32'(o_prog_addr), 32'd0);
        check({name, "_prog_data"}, 32'(o_prog_data), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence
    initial begin
        int en0;
        i_reset    = 1'b1;
        i_rx_data  = 8'h00;
        i_rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("por");
        @(posedge clk);
        #1 i_reset = 1'b0;
        @(negedge clk);
        check("por_bip_reset_hold", 32'(o_bip_reset), 32'd1);
        @(posedge clk);
        #1;
        check("por_bip_reset_drop", 32'(o_bip_reset), 32'd0);

        // unknown command byte is ignored
        en0 = en_seen;
        send_byte(8'h41);
        repeat (5) @(posedge clk);
        #1;
        check("unknown_no_en", 32'(en_seen - en0), 32'd0);
        check("unknown_no_reset", 32'(o_bip_reset), 32'd0);

        // T1: load three words
        load_words = '{16'h1234, 16'h5678, 16'h9ABC};
        prog_log.delete();
        do_load("t1");
        check("t1_w0", 32'(prog_log[0]), 32'({11'd0, 16'h1234}));
        check("t1_w1", 32'(prog_log[1]), 32'({11'd1, 16'h5678}));
        check("t1_w2", 32'(prog_log[2]), 32'({11'd2, 16'h9ABC}));

        // T2: run until HLT, five enables
        do_exec(1'b1, "t2");
        check("t2_b0", 32'(tx_log[0]), 32'h00);
        check("t2_b1", 32'(tx_log[1]), 32'h05);
        check("t2_b2", 32'(tx_log[2]), 32'h00);
        check("t2_b3", 32'(tx_log[3]), 32'h2A);
        check("t2_b4", 32'(tx_log[4]), 32'h00);
        check("t2_b5", 32'(tx_log[5]), 32'h05);

        // T3: reload, then three single steps
        do_load("t3_load");
        for (int k = 1; k <= 3; k++) begin
            do_exec(1'b0, "t3");
            check("t3_cyc_hi", 32'(tx_log[4]), 32'h00);
            check("t3_cyc_lo", 32'(tx_log[5]), 32'(k));
        end

        // T4: step while halted
        halt_force = 1'b1;
        do_exec(1'b0, "t4");
        check("t4_cyc_lo", 32'(tx_log[5]), 32'h03);
        halt_force = 1'b0;

        // T5: long transmitter busy, 'R' during report dropped
        busy_len = 20;
        push_report();
        tx_log.delete();
        en0 = en_seen;
        send_byte(8'h50);
        repeat (10) @(posedge clk);
        #1;
        send_byte(8'h52);
        wait_report("t5");
        repeat (30) @(posedge clk);
        #1;
        check("t5_tx_count", 32'(tx_log.size()), 32'd6);
        check("t5_run_dropped", 32'(en_seen - en0), 32'd0);
        busy_len = 2;

        // empty load clears the cycle counter
        load_words.delete();
        do_load("n0");
        push_report();
        tx_log.delete();
        send_byte(8'h50);
        wait_report("n0_rpt");
        check("n0_cyc_lo", 32'(tx_log[5]), 32'h00);

        // T6: reset in the middle of a load
        prog_log.delete();
        exp_prog.push_back({11'd0, 16'h1122});
        send_byte(8'h4C);
        send_byte(8'h04);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        i_reset = 1'b1;
        @(negedge clk);
        check_reset_vals("t6");
        repeat (2) @(posedge clk);
        #1 i_reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("t6_write_count", 32'(prog_log.size()), 32'd1);
        check("t6_w0", 32'(prog_log[0]), 32'({11'd0, 16'h1122}));
        check("t6_no_pending", 32'(exp_prog.size()), 32'd0);
        exp_pc  = 0;
        exp_cyc = 0;
        push_report();
        tx_log.delete();
        send_byte(8'h50);
        wait_report("t6_rpt");
        check("t6_cyc_hi", 32'(tx_log[4]), 32'h00);
        check("t6_cyc_lo", 32'(tx_log[5]), 32'h00);

        check("end_prog_q", 32'(exp_prog.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
